ram_dp_param: RTL and testbench
===============================

// Module: ram_dp_param
// PURPOSE
//  Parametrised successor of the single-port factorial-core RAM.
//  - Port A: read/write with byte enables. Port B: read-only.
//  - Read latency is configurable. A valid flag accompanies each read result.
//  - Hardware zero-clear sequence on reset, replacing the initial-block init.
//  - Holds operands and partial products for the factorial datapath and the host readback path.
// PARAMETERS
//  DATA_W    64  word width in bits; must be a multiple of 8
//  ADDR_W    8   address width; DEPTH = 2**ADDR_W words
//  RD_LAT    1   read latency in cycles; legal values 1 or 2
//  RDW_MODE  0   collision rule when A writes and B reads the same address:
//                0 = READ_FIRST (B returns old word), 1 = WRITE_FIRST (B returns merged new word)
// PORTS
//  clk        in   1         clock; all state changes on posedge
//  rst        in   1         synchronous reset, active-high
//  init_busy  out  1         high while the zero-clear sweep runs
//  a_cen      in   1         port A chip enable
//  a_wen      in   1         port A write enable; 1 = write, 0 = read (qualified by a_cen)
//  a_addr     in   ADDR_W    port A address
//  a_be       in   DATA_W/8  port A byte enables; bit i covers din[8i+7:8i]
//  a_din      in   DATA_W    port A write data
//  a_dout     out  DATA_W    port A read data
//  a_dvalid   out  1         a_dout holds a read result this cycle
//  b_cen      in   1         port B read enable
//  b_addr     in   ADDR_W    port B address
//  b_dout     out  DATA_W    port B read data
//  b_dvalid   out  1         b_dout holds a read result this cycle
// BEHAVIOUR
//  Reset:
//  - rst high: init_busy=1, clear counter=0, all pipeline stages cleared.
//  - a_dout, b_dout = 0; a_dvalid, b_dvalid = 0 from the next edge.
//  Init sweep:
//  - After rst deasserts, one word is zeroed per cycle at addresses 0..DEPTH-1.
//  - init_busy falls on the edge that writes DEPTH-1, so it is high for exactly DEPTH cycles after rst.
//  - rst reasserted mid-sweep restarts the sweep at 0.
//  - While init_busy=1, all A and B requests are ignored: no write, douts 0, valids 0.
//  Port A write (a_cen=1, a_wen=1):
//  - mem[a_addr] byte i <= a_din byte i for each set a_be[i]; other bytes are kept.
//  - No read is issued. The A result slot is 0 and a_dvalid=0 (matches the legacy write-returns-0 behaviour).
//  - a_be=0 is a legal no-op write.
//  Port A read (a_cen=1, a_wen=0):
//  - mem[a_addr] appears on a_dout with a_dvalid=1 exactly RD_LAT edges after the request edge.
//  Port B read (b_cen=1):
//  - Same as the A read, using b_addr, b_dout and b_dvalid.
//  Idle (cen=0):
//  - The slot carries dout=0 and dvalid=0 after RD_LAT. Outputs are zero, never held.
//  Pipelining:
//  - One request per port per cycle, fully pipelined, no stalls.
//  - The RD_LAT=2 stage is a plain register copy of the stage-1 data and valid.
//  Collisions:
//  - A write + B read at the same address, same cycle: B result follows RDW_MODE.
//  - WRITE_FIRST returns the byte-merged word (new bytes where a_be is set, old bytes elsewhere).
//  - A and B reading the same address is always legal; both get identical data.
//  Addressing: no wrap or overflow; ADDR_W covers DEPTH exactly.
//  Reset during reads: in-flight reads are discarded; no dvalid is emitted for them.
// STRUCTURE
//  Package ram_pkg:
//  - localparams RDW_READ_FIRST=0, RDW_WRITE_FIRST=1.
//  - function byte_merge(old, new, be) returning the merged word.
//  Sub-module ram_rd_pipe #(DATA_W, RD_LAT):
//  - data/valid delay line, one instance per port, zeroed by rst.
//  Top level: memory array, init counter, write merge, collision mux.
// TESTING
//  1. Assert rst 1 cycle -> init_busy high for 256 cycles; then B reads of addrs 0, 128, 255 return 0 with b_dvalid=1.
//  2. A write addr 5 = 64'h1122334455667788 with be=8'hFF, then be=8'h0F din=64'hAAAAAAAABBBBBBBB -> A read addr 5 returns 64'h11223344BBBBBBBB.
//  3. RD_LAT=2: back-to-back B reads of addrs 1,2,3 on consecutive cycles -> data appears on cycles +2,+3,+4 with b_dvalid high 3 cycles; cen low -> dout=0, dvalid=0.
//  4. Addr 9 holds 64'h0. Same cycle: A writes 64'hFFFF at addr 9 (be=FF) and B reads addr 9 -> READ_FIRST: b_dout=0; WRITE_FIRST: b_dout=64'hFFFF.
//  5. A write with a_cen=1 -> a_dout=0, a_dvalid=0 after RD_LAT.
//  6. Requests issued while init_busy=1 -> memory unchanged, valids 0. rst at sweep cycle 100 -> init_busy stays high 256 more cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and helpers for the dual-port parametrised RAM.
package ram_pkg;

    // Collision rule selectors for a same-address A write / B read.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    typedef logic [MAX_DATA_W-1:0] word_max_t;
    typedef logic [MAX_BE_W-1:0]   be_max_t;

    // Replace every byte of old_word whose enable bit is set with the byte of wr_word.
    function automatic word_max_t byte_merge(input word_max_t old_word,
                                             input word_max_t wr_word,
                                             input be_max_t   be);
        word_max_t merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wr_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: adds RD_LAT-1 plain register stages behind the
// registered memory read so the total read latency is RD_LAT.
module ram_rd_pipe #(
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    localparam int EXTRA = RD_LAT - 1;

    generate
        if (EXTRA <= 0) begin : g_pass
            // The memory output register already provides the single cycle.
            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_dly
            genvar gi;
            for (gi = 0; gi < EXTRA; gi++) begin : g_stage
                logic [DATA_W-1:0] data_reg;
                logic              valid_reg;
                logic [DATA_W-1:0] src_data;
                logic              src_valid;

                if (gi == 0) begin : g_first
                    assign src_data  = in_data;
                    assign src_valid = in_valid;
                end else begin : g_next
                    assign src_data  = g_stage[gi-1].data_reg;
                    assign src_valid = g_stage[gi-1].valid_reg;
                end

                // One register stage; reset flushes any in-flight result.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_reg  <= '0;
                        valid_reg <= 1'b0;
                    end else begin
                        data_reg  <= src_data;
                        valid_reg <= src_valid;
                    end
                end
            end

            assign out_data  = g_stage[EXTRA-1].data_reg;
            assign out_valid = g_stage[EXTRA-1].valid_reg;
        end
    endgenerate

endmodule

// File: rtl/ram_dp_param.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only,
// configurable read latency, hardware zero-clear sweep after reset.
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                a_cen,
    input  logic                a_wen,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_dvalid,
    input  logic                b_cen,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_dvalid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;

    logic              a_wr_req;
    logic              a_rd_req;
    logic              b_rd_req;
    logic              collide;

    logic [DATA_W-1:0] a_raw_reg;
    logic [DATA_W-1:0] b_raw_reg;
    logic              a_vld_reg;
    logic              b_vld_reg;
    logic              b_fwd_reg;
    logic [DATA_W-1:0] fwd_din_reg;
    logic [BE_W-1:0]   fwd_be_reg;

    logic [DATA_W-1:0] b_merged;
    logic [DATA_W-1:0] a_s1_data;
    logic [DATA_W-1:0] b_s1_data;

    // Requests are only honoured once the clear sweep is done and reset is low.
    assign a_wr_req = a_cen &  a_wen & ~busy_reg & ~rst;
    assign a_rd_req = a_cen & ~a_wen & ~busy_reg & ~rst;
    assign b_rd_req = b_cen &           ~busy_reg & ~rst;
    assign collide  = a_wr_req & b_rd_req & (a_addr == b_addr);

    assign init_busy = busy_reg;

    // Clear-sweep sequencer: walks 0..DEPTH-1, drops busy on the last address.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg    <= 1'b1;
            clr_cnt_reg <= '0;
        end else if (busy_reg) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
            if (&clr_cnt_reg) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // Memory write port: sweep zeroing takes priority, else byte-enabled A write.
    always_ff @(posedge clk) begin
        if (busy_reg && !rst) begin
            mem[clr_cnt_reg] <= '0;
        end else if (a_wr_req) begin
            for (int i = 0; i < BE_W; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                end
            end
        end
    end

    // Registered reads; these return the pre-write contents on a collision.
    always_ff @(posedge clk) begin
        a_raw_reg   <= mem[a_addr];
        b_raw_reg   <= mem[b_addr];
        fwd_din_reg <= a_din;
        fwd_be_reg  <= a_be;
    end

    // Stage-1 request tags; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_reg <= 1'b0;
            b_vld_reg <= 1'b0;
            b_fwd_reg <= 1'b0;
        end else begin
            a_vld_reg <= a_rd_req;
            b_vld_reg <= b_rd_req;
            b_fwd_reg <= (RDW_MODE == RDW_WRITE_FIRST) && collide;
        end
    end

    assign b_merged = DATA_W'(byte_merge(MAX_DATA_W'(b_raw_reg),
                                         MAX_DATA_W'(fwd_din_reg),
                                         MAX_BE_W'(fwd_be_reg)));

    // Stage-1 result slots: zero unless a read was issued; B may take the forwarded merge.
    always_comb begin
        a_s1_data = '0;
        b_s1_data = '0;
        if (a_vld_reg) begin
            a_s1_data = a_raw_reg;
        end
        if (b_vld_reg) begin
            b_s1_data = b_fwd_reg ? b_merged : b_raw_reg;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_s1_data),
        .in_valid  (a_vld_reg),
        .out_data  (a_dout),
        .out_valid (a_dvalid)
    );

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_s1_data),
        .in_valid  (b_vld_reg),
        .out_data  (b_dout),
        .out_valid (b_dvalid)
    );

endmodule

// File: tb/tb_ram_dp_param.sv
// Self-checking bench: two instances (RD_LAT=1/READ_FIRST and RD_LAT=2/WRITE_FIRST)
// share one stimulus stream and are compared against a word-array reference model.
module tb_ram_dp_param;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst;
    logic              a_cen;
    logic              a_wen;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_be;
    logic [DATA_W-1:0] a_din;
    logic              b_cen;
    logic [ADDR_W-1:0] b_addr;

    logic              busy0, busy1;
    logic [DATA_W-1:0] a0_dout, b0_dout, a1_dout, b1_dout;
    logic              a0_dvalid, b0_dvalid, a1_dvalid, b1_dvalid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                init_left = 0;
    logic [DATA_W-1:0] ha_d  [2];
    logic              ha_v  [2];
    logic [DATA_W-1:0] hb0_d;
    logic              hb0_v;
    logic [DATA_W-1:0] hb1_d [2];
    logic              hb1_v [2];

    ram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .init_busy(busy0),
        .a_cen(a_cen), .a_wen(a_wen), .a_addr(a_addr), .a_be(a_be), .a_din(a_din),
        .a_dout(a0_dout), .a_dvalid(a0_dvalid),
        .b_cen(b_cen), .b_addr(b_addr), .b_dout(b0_dout), .b_dvalid(b0_dvalid)
    );

    ram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .init_busy(busy1),
        .a_cen(a_cen), .a_wen(a_wen), .a_addr(a_addr), .a_be(a_be), .a_din(a_din),
        .a_dout(a1_dout), .a_dvalid(a1_dvalid),
        .b_cen(b_cen), .b_addr(b_addr), .b_dout(b1_dout), .b_dvalid(b1_dvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic ac, input logic aw, input int aa, input logic [7:0] be,
                           input logic [63:0] din, input logic bc, input int ba);
        a_cen  = ac;
        a_wen  = aw;
        a_addr = ADDR_W'(aa);
        a_be   = be;
        a_din  = din;
        b_cen  = bc;
        b_addr = ADDR_W'(ba);
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b0, 0);
    endtask

    // Advance one clock: predict this edge's results from the model, then check all outputs.
    task automatic step();
        logic [63:0] ra, rb0, rb1, old_w;
        logic        va, vb;
        logic        busy_now;
        ra = '0; rb0 = '0; rb1 = '0; va = 1'b0; vb = 1'b0;
        busy_now = (init_left > 0);

        if (rst || a_cen || b_cen) begin
            $display("t=%0t rst=%0d busy=%0d a_cen=%0d a_wen=%0d a_addr=%0d a_be=%h a_din=%h b_cen=%0d b_addr=%0d",
                     $time, rst, busy_now, a_cen, a_wen, a_addr, a_be, a_din, b_cen, b_addr);
        end

        if (!rst && !busy_now) begin
            if (a_cen && !a_wen) begin
                va = 1'b1;
                ra = model_mem[a_addr];
            end
            if (b_cen) begin
                vb    = 1'b1;
                old_w = model_mem[b_addr];
                rb0   = old_w;
                rb1   = old_w;
                if (a_cen && a_wen && a_addr == b_addr) begin
                    for (int i = 0; i < 8; i++) begin
                        if (a_be[i]) rb1[8*i +: 8] = a_din[8*i +: 8];
                    end
                end
            end
            if (a_cen && a_wen) begin
                for (int i = 0; i < 8; i++) begin
                    if (a_be[i]) model_mem[a_addr][8*i +: 8] = a_din[8*i +: 8];
                end
            end
        end

        @(posedge clk);

        if (rst) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            ha_d[0] = '0; ha_d[1] = '0; ha_v[0] = 1'b0; ha_v[1] = 1'b0;
            hb0_d = '0; hb0_v = 1'b0;
            hb1_d[0] = '0; hb1_d[1] = '0; hb1_v[0] = 1'b0; hb1_v[1] = 1'b0;
        end else begin
            if (init_left > 0) init_left--;
            ha_d[1] = ha_d[0]; ha_v[1] = ha_v[0];
            ha_d[0] = ra;      ha_v[0] = va;
            hb0_d = rb0;       hb0_v = vb;
            hb1_d[1] = hb1_d[0]; hb1_v[1] = hb1_v[0];
            hb1_d[0] = rb1;      hb1_v[0] = vb;
        end

        #1;
        check_eq("d0_busy",   64'(busy0),     64'(init_left > 0));
        check_eq("d1_busy",   64'(busy1),     64'(init_left > 0));
        check_eq("d0_a_dout", a0_dout,        ha_d[0]);
        check_eq("d0_a_vld",  64'(a0_dvalid), 64'(ha_v[0]));
        check_eq("d0_b_dout", b0_dout,        hb0_d);
        check_eq("d0_b_vld",  64'(b0_dvalid), 64'(hb0_v));
        check_eq("d1_a_dout", a1_dout,        ha_d[1]);
        check_eq("d1_a_vld",  64'(a1_dvalid), 64'(ha_v[1]));
        check_eq("d1_b_dout", b1_dout,        hb1_d[1]);
        check_eq("d1_b_vld",  64'(b1_dvalid), 64'(hb1_v[1]));
    endtask

    // Hold the current inputs until init_busy drops; returns the number of busy cycles seen.
    task automatic run_sweep(output int cycles);
        cycles = 0;
        while (busy0 && cycles < 400) begin
            step();
            cycles++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        rst = 1'b0;
        idle();

        // Reset, full sweep length, reads of cleared memory
        do_reset();
        run_sweep(busy_cycles);
        check_eq("sweep_len", 64'(busy_cycles), 64'd256);
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 0);   step();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 128); step();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 255); step();
        idle(); step(); step();

        // Full write then partial byte-enable write, read back on A
        set_req(1'b1, 1'b1, 5, 8'hFF, 64'h1122334455667788, 1'b0, 0); step();
        set_req(1'b1, 1'b1, 5, 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b0, 0); step();
        set_req(1'b1, 1'b0, 5, 8'h00, 64'h0, 1'b0, 0); step();
        check_eq("merge_a5_lat1", a0_dout, 64'h11223344BBBBBBBB);
        idle(); step();
        check_eq("merge_a5_lat2", a1_dout, 64'h11223344BBBBBBBB);
        step();

        // Back-to-back B reads of 1,2,3 after seeding them, then cen low
        set_req(1'b1, 1'b1, 1, 8'hFF, 64'h0101010101010101, 1'b0, 0); step();
        set_req(1'b1, 1'b1, 2, 8'hFF, 64'h0202020202020202, 1'b0, 0); step();
        set_req(1'b1, 1'b1, 3, 8'hFF, 64'h0303030303030303, 1'b0, 0); step();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 1); step();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 2); step();
        set_req(1'b0, 1'b0, 0, 8'h00, 64'h0, 1'b1, 3); step();
        check_eq("lat2_b_addr2", b1_dout, 64'h0202020202020202);
        idle(); step(); step(); step();

        // Same-address A write / B read collision on addr 9
        set_req(1'b1, 1'b1, 9, 8'hFF, 64'hFFFF, 1'b1, 9); step();
        check_eq("rf_collide", b0_dout, 64'h0);
        idle(); step();
        check_eq("wf_collide", b1_dout, 64'hFFFF);
        step();

        // Reset mid-sweep, with requests held during the sweep
        do_reset();
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(1'b1, 1'b1, 20, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b1, 20);
        run_sweep(busy_cycles);
        check_eq("sweep_restart_len", 64'(busy_cycles), 64'd256);
        idle();
        set_req(1'b1, 1'b0, 20, 8'h00, 64'h0, 1'b1, 20); step();
        idle(); step(); step();

        // Randomized traffic over a small address window, with one reset in the middle
        for (int i = 0; i < 700; i++) begin
            logic [3:0] aa;
            logic [3:0] ba;
            aa = 4'($urandom_range(0, 15));
            ba = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom_range(0, 15));
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'(aa),
                    8'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)), int'(ba));
            rst = (i == 350);
            step();
        end
        rst = 1'b0;
        idle(); step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
